// File: rtl/ysyx_22041071_axi_rd_arb.sv
// Two-master read arbiter feeding a single-outstanding AXI read engine (m0 = ifetch, m1 = load).
// Define YSYX_22041071_ARB_FIXED_PRIO_EN for fixed priority (m1 wins); otherwise round-robin.
module ysyx_22041071_axi_rd_arb #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8,
  parameter int ID_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req_valid,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [LEN_W-1:0]  m0_len,
  input  logic [1:0]        m0_size,
  output logic              m0_req_ready,
  output logic              m0_r_valid,
  output logic [DATA_W-1:0] m0_r_data,
  output logic [1:0]        m0_r_resp,
  output logic              m0_r_last,
  input  logic              m1_req_valid,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [LEN_W-1:0]  m1_len,
  input  logic [1:0]        m1_size,
  output logic              m1_req_ready,
  output logic              m1_r_valid,
  output logic [DATA_W-1:0] m1_r_data,
  output logic [1:0]        m1_r_resp,
  output logic              m1_r_last,
  output logic              dn_ar_valid,
  output logic [ID_W-1:0]   dn_id,
  output logic [ADDR_W-1:0] dn_addr,
  output logic [LEN_W-1:0]  dn_len,
  output logic [1:0]        dn_size,
  input  logic              dn_ar_ready,
  input  logic              dn_r_valid,
  input  logic [DATA_W-1:0] dn_r_data,
  input  logic [1:0]        dn_r_resp,
  input  logic              dn_r_last,
  input  logic [ID_W-1:0]   dn_r_id,
  output logic              arb_err
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t              state_q, state_d;
  logic                rr_ptr_q, rr_ptr_d;
  logic                owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [1:0]          size_q, size_d;
  logic [LEN_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic                arb_err_q, arb_err_d;

  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0]          r_valid;
  logic [1:0]          r_last;
  logic [DATA_W-1:0]   r_data [2];
  logic [1:0]          r_resp [2];
  logic                any_req;
  logic                winner;

  assign req_valid = {m1_req_valid, m0_req_valid};
  assign any_req   = |req_valid;

`ifdef YSYX_22041071_ARB_FIXED_PRIO_EN
  assign winner = m1_req_valid;
`else
  // On contention rr_ptr names the preferred master.
  assign winner = (&req_valid) ? rr_ptr_q : m1_req_valid;
`endif

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_master
      localparam logic MY_IDX = (gi == 1);
      logic sel;
      assign sel           = (state_q == S_DATA) && (owner_q == MY_IDX);
      assign req_ready[gi] = (state_q == S_IDLE) && any_req && (winner == MY_IDX);
      assign r_valid[gi]   = sel & dn_r_valid;
      assign r_last[gi]    = sel & dn_r_last;
      assign r_data[gi]    = sel ? dn_r_data : '0;
      assign r_resp[gi]    = sel ? dn_r_resp : 2'b00;
    end
  endgenerate

  assign m0_req_ready = req_ready[0];
  assign m1_req_ready = req_ready[1];
  assign m0_r_valid   = r_valid[0];
  assign m1_r_valid   = r_valid[1];
  assign m0_r_last    = r_last[0];
  assign m1_r_last    = r_last[1];
  assign m0_r_data    = r_data[0];
  assign m1_r_data    = r_data[1];
  assign m0_r_resp    = r_resp[0];
  assign m1_r_resp    = r_resp[1];

  assign dn_ar_valid = (state_q == S_ADDR);
  assign dn_id       = ID_W'(owner_q);
  assign dn_addr     = addr_q;
  assign dn_len      = len_q;
  assign dn_size     = size_q;
  assign arb_err     = arb_err_q;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    len_d      = len_q;
    size_d     = size_q;
    beat_cnt_d = beat_cnt_q;
    arb_err_d  = arb_err_q;
    case (state_q)
      S_IDLE: begin
        if (dn_r_valid) arb_err_d = 1'b1;
        if (any_req) begin
          owner_d = winner;
          addr_d  = winner ? m1_addr : m0_addr;
          len_d   = winner ? m1_len  : m0_len;
          size_d  = winner ? m1_size : m0_size;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (dn_r_valid) arb_err_d = 1'b1;
        if (dn_ar_ready) begin
          state_d    = S_DATA;
          beat_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (dn_r_valid) begin
          if (!(&beat_cnt_q)) beat_cnt_d = beat_cnt_q + LEN_W'(1);
          if (dn_r_id != ID_W'(owner_q)) arb_err_d = 1'b1;
          if (dn_r_last) begin
            // beat_cnt counts beats before this one, so a well-formed burst ends at len.
            if (beat_cnt_q != len_q) arb_err_d = 1'b1;
            state_d = S_IDLE;
`ifndef YSYX_22041071_ARB_FIXED_PRIO_EN
            rr_ptr_d = ~owner_q;
`endif
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= 1'b0;
      owner_q    <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= 2'b00;
      beat_cnt_q <= '0;
      arb_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      size_q     <= size_d;
      beat_cnt_q <= beat_cnt_d;
      arb_err_q  <= arb_err_d;
    end
  end

endmodule

// File: doc/ysyx_22041071_axi_rd_arb.md
Name: ysyx_22041071_axi_rd_arb

Overview:
Two-master read arbiter in front of the single-outstanding AXI read engine. Master 0 is instruction fetch; master 1 is data load.
- Selects one requester, registers its request and drives it to the engine's cpu-side AR interface.
- Routes the returning R beats back to the owner only.
- Allows one transaction in flight; the next grant is given only after the last beat.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, read data width
LEN_W, 8, burst length width (AXI len, beats-1)
ID_W, 4, transaction ID width; master n uses ID n

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
m0_req_valid / m1_req_valid  in  1  read request; held stable until req_ready
m0_addr / m1_addr  in  ADDR_W  byte address
m0_len / m1_len  in  LEN_W  beats-1
m0_size / m1_size  in  2  00:1B 01:2B 10:4B 11:8B
m0_req_ready / m1_req_ready  out  1  one-cycle accept pulse
m0_r_valid / m1_r_valid  out  1  beat valid for this master
m0_r_data / m1_r_data  out  DATA_W  beat data
m0_r_resp / m1_r_resp  out  2  beat response
m0_r_last / m1_r_last  out  1  final beat
dn_ar_valid  out  1  request to engine
dn_id  out  ID_W  owner ID
dn_addr  out  ADDR_W  latched address
dn_len  out  LEN_W  latched len
dn_size  out  2  latched size
dn_ar_ready  in  1  engine accepts
dn_r_valid  in  1  beat from engine (one-cycle pulse per beat)
dn_r_data  in  DATA_W  beat data
dn_r_resp  in  2  beat response
dn_r_last  in  1  final beat
dn_r_id  in  ID_W  beat ID
arb_err  out  1  sticky protocol error flag

Behaviour:
- Reset:
  - All outputs are 0.
  - State IDLE, rr_ptr=0 (master 0 preferred), owner=0, beat_cnt=0, arb_err=0.
  - A reset asserted mid-transaction aborts it; the downstream engine is reset with the same reset.
- States: IDLE, ADDR, DATA.
- IDLE:
  - If any mX_req_valid: the winner is the only valid master, or the master indicated by rr_ptr if both are valid.
  - Winner's mX_req_ready=1 combinationally in this cycle only.
  - Latch addr, len, size, owner. Next state ADDR.
  - Loser's req_ready stays 0; its request stays pending.
- ADDR:
  - dn_ar_valid=1, dn_id=owner, dn_addr/len/size from latches.
  - Fields stay stable until dn_ar_ready. On dn_ar_valid & dn_ar_ready, go to DATA with beat_cnt=0.
- DATA:
  - Owner's m_r_valid = dn_r_valid; data, resp and last are passed through combinationally (zero latency).
  - The non-owner sees all R outputs at 0.
  - Each beat increments beat_cnt (saturates at all-ones).
  - On dn_r_valid & dn_r_last: go to IDLE and set rr_ptr = ~owner (the other master is preferred next).
- Latency: request accepted at cycle N; dn_ar_valid first high at N+1. Earliest next grant is the cycle after the last beat.
- arb_err is set, and stays set until reset, when any of these occur:
  - dn_r_valid in IDLE or ADDR (beat ignored, not routed);
  - dn_r_valid in DATA with dn_r_id != owner (beat still routed);
  - dn_r_last with beat_cnt != latched len (transaction still completes).
- A requester dropping valid before ready is a requester protocol violation; no behaviour is defined.
- dn_r_resp errors (SLVERR/DECERR) are passed through unchanged; the arbiter takes no action on them.

Optional Feature:
YSYX_22041071_ARB_FIXED_PRIO_EN
- Defined: fixed priority. Master 1 (data) always wins a simultaneous request; rr_ptr is unused and held at 0.
- Undefined: round-robin via rr_ptr as described in Behaviour.

Test Plan:
1. Reset, then m0 requests addr=0x8000_0000, len=0, size=11; dn_ar_ready=1 next cycle; one beat 0x1122334455667788 with last. Required: m0_req_ready at cycle 0, dn_ar_valid at cycle 1 with dn_id=0, m0_r_valid/data/last in the beat cycle, arb_err=0.
2. m0 and m1 valid in the same cycle after reset. Required: m0 is granted first. After its last beat m1 (addr 0x8000_1000) is granted, and dn_id=1 in ADDR. Then both valid again: m0 is granted.
3. m1 burst len=3 with dn_ar_ready held low for 4 cycles. Required: dn_addr/len/size are stable throughout. Four beats go only to m1, m1_r_last is on the 4th beat, and m0_r_valid stays 0.
4. dn_r_last on the 2nd beat of a len=3 burst. Required: return to IDLE, arb_err=1 and stays 1. A subsequent clean transaction completes normally.
5. Reset asserted in ADDR with dn_ar_ready=0. Required: the next cycle has state IDLE, dn_ar_valid=0, all req_ready=0 and arb_err=0; a new m1 request is granted normally.
6. With YSYX_22041071_ARB_FIXED_PRIO_EN defined, m0 and m1 request back-to-back three times. Required: m1 wins every simultaneous contest.
